// File: rtl/sw_debounce_pkg.sv
// Shared constants and the counter-width helper for the switch debouncer.
package sw_debounce_pkg;

   localparam int unsigned SW_W_DEF            = 8;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 20000;

   // Width that holds 0..cycles; the counter itself never goes past cycles-1.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch/enable inputs and debounced outputs of sw_debounce.
// Optional macro SW_DEBOUNCE_EVT_EN adds the per-bit rise event vector.
interface sw_debounce_if #(
   parameter int unsigned SW_W = sw_debounce_pkg::SW_W_DEF
);

   logic [SW_W-1:0] sw_in;
   logic            en_in;
   logic [SW_W-1:0] x;
   logic            en;
   logic            changed;
`ifdef SW_DEBOUNCE_EVT_EN
   logic [SW_W-1:0] rise;

   modport master (output sw_in, en_in, input x, en, changed, rise);
   modport slave  (input sw_in, en_in, output x, en, changed, rise);
`else
   modport master (output sw_in, en_in, input x, en, changed);
   modport slave  (input sw_in, en_in, output x, en, changed);
`endif

endinterface

// File: rtl/sw_debounce_deb_bit.sv
// One debounced bit: two-flop synchronizer, run-length counter, stable flop.
module deb_bit
   import sw_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_stable,
   output logic o_toggle
);

   localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_meta;
   logic          r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_stable;
   logic          r_toggle;
   logic          w_hit;

   // The increment that would reach DEBOUNCE_CYCLES flips the level instead.
   assign w_hit = (r_sync != r_stable) && (r_cnt == CNT_LAST);

   // Bring the raw asynchronous level into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
      end
   end

   // Count consecutive disagreeing cycles; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (r_sync == r_stable) begin
         r_cnt <= '0;
      end else if (w_hit) begin
         r_cnt    <= '0;
         r_stable <= ~r_stable;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Strobe is high during the first cycle the new stable level is visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_toggle <= 1'b0;
      end else begin
         r_toggle <= w_hit;
      end
   end

   assign o_stable = r_stable;
   assign o_toggle = r_toggle;

endmodule

// File: rtl/sw_debounce.sv
// Debouncer for SW_W switches plus one enable switch, with a change pulse.
// Optional macro SW_DEBOUNCE_EVT_EN adds a per-bit 0->1 event output (rise).
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned SW_W            = SW_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   sw_debounce_if.slave  bus
);

   localparam int unsigned NB = SW_W + 1;

   // Bit SW_W carries the enable switch, the rest are the switches.
   logic [NB-1:0] w_raw;
   logic [NB-1:0] w_stable;
   logic [NB-1:0] w_toggle;
   logic          r_changed;

   assign w_raw = {bus.en_in, bus.sw_in};

   for (genvar g = 0; g < NB; g++) begin : g_bit
      deb_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb_bit (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_raw    (w_raw[g]),
         .o_stable (w_stable[g]),
         .o_toggle (w_toggle[g])
      );
   end

   // One pulse per edge on which any bit flipped, however many flipped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_toggle;
      end
   end

   assign bus.x       = w_stable[SW_W-1:0];
   assign bus.en      = w_stable[SW_W];
   assign bus.changed = r_changed;

`ifdef SW_DEBOUNCE_EVT_EN
   logic [SW_W-1:0] r_rise;

   // A bit that just toggled and is now high went 0->1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rise <= '0;
      end else begin
         r_rise <= w_toggle[SW_W-1:0] & w_stable[SW_W-1:0];
      end
   end

   assign bus.rise = r_rise;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with DEBOUNCE_CYCLES=4: directed cases plus random bouncing
// stimulus compared every cycle against a window-based reference model.
module tb_sw_debounce;
   import sw_debounce_pkg::*;

   localparam int D  = 4;
   localparam int W  = 8;
   localparam int NB = W + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   sw_debounce_if #(.SW_W(W)) bus ();

   sw_debounce #(
      .DEBOUNCE_CYCLES (D),
      .SW_W            (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a bit flips when the last D synchronized samples all
   // disagree with its current level; sync sample = raw from two edges earlier.
   logic [NB-1:0] m_p1 = '0;
   logic [NB-1:0] m_p2 = '0;
   logic [NB-1:0] m_x  = '0;
   logic [NB-1:0] m_tog = '0;
   logic          m_changed = 1'b0;
   logic [W-1:0]  m_rise = '0;
   logic [NB-1:0] m_hist[$];

   task automatic model_reset();
      m_p1 = '0; m_p2 = '0; m_x = '0; m_tog = '0;
      m_changed = 1'b0; m_rise = '0;
      m_hist.delete();
   endtask

   task automatic model_step();
      logic [NB-1:0] sync;
      logic [NB-1:0] tog;
      bit            all_diff;
      sync = m_p2;
      m_p2 = m_p1;
      m_p1 = {bus.en_in, bus.sw_in};
      m_hist.push_back(sync);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      m_changed = |m_tog;
      m_rise    = m_tog[W-1:0] & m_x[W-1:0];
      tog = '0;
      if (m_hist.size() == D) begin
         for (int b = 0; b < NB; b++) begin
            all_diff = 1'b1;
            foreach (m_hist[i]) if (m_hist[i][b] == m_x[b]) all_diff = 1'b0;
            tog[b] = all_diff;
         end
      end
      m_x   = m_x ^ tog;
      m_tog = tog;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
   end

   // Every-cycle comparison, sampled well after the active edge.
   initial forever begin
      @(posedge clk);
      #3;
      chk("model_x", bus.x, m_x[W-1:0]);
      chk("model_en", bus.en, m_x[W]);
      chk("model_changed", bus.changed, m_changed);
`ifdef SW_DEBOUNCE_EVT_EN
      chk("model_rise", bus.rise, m_rise);
`endif
   end

   initial begin
      int r;
      int idx;
      int noisy;
      bus.sw_in = '0;
      bus.en_in = 1'b0;
      noisy = 0;
      repeat (3) @(negedge clk);
      chk("rst_x", bus.x, 0);
      chk("rst_en", bus.en, 0);
      chk("rst_changed", bus.changed, 0);
      rst_n = 1'b1;

      // Quiet inputs: nothing moves.
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_x", bus.x, 0);
         chk("idle_changed", bus.changed, 0);
      end

      // Clean 00 -> 81: visible after exactly D+2 edges, then one changed pulse.
      bus.sw_in = 8'h81;
      repeat (5) @(negedge clk);
      chk("clean_x_early", bus.x, 0);
      @(negedge clk);
      chk("clean_x", bus.x, 8'h81);
      chk("clean_chg_same", bus.changed, 0);
      @(negedge clk);
      chk("clean_chg_pulse", bus.changed, 1);
      @(negedge clk);
      chk("clean_chg_end", bus.changed, 0);
      bus.sw_in = 8'h00;
      repeat (10) @(negedge clk);
      chk("clean_back", bus.x, 0);

      // Bit 3 bounces 1-0-1-0 one cycle each, then settles high.
      for (int i = 0; i < 4; i++) begin
         bus.sw_in[3] = ~bus.sw_in[3];
         @(negedge clk);
         chk("bounce_x3", bus.x[3], 0);
      end
      bus.sw_in[3] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("settle_x3_early", bus.x[3], 0);
      end
      @(negedge clk);
      chk("settle_x3", bus.x, 8'h08);
      bus.sw_in = 8'h00;
      repeat (10) @(negedge clk);

      // 3-cycle enable glitch is filtered out.
      bus.en_in = 1'b1;
      repeat (3) @(negedge clk);
      bus.en_in = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("glitch_en", bus.en, 0);
         chk("glitch_changed", bus.changed, 0);
      end

      // Reset in the middle of a count discards it.
      bus.sw_in = 8'h10;
      repeat (8) @(negedge clk);
      chk("pre_rst_x", bus.x, 8'h10);
      bus.sw_in = 8'h11;
      repeat (5) @(negedge clk);
      chk("midcount_x", bus.x, 8'h10);
      rst_n = 1'b0;
      #1;
      chk("async_rst_x", bus.x, 0);
      chk("async_rst_changed", bus.changed, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_x_early", bus.x, 0);
      @(negedge clk);
      chk("post_rst_x", bus.x, 8'h11);
      @(negedge clk);
      chk("post_rst_chg", bus.changed, 1);
      @(negedge clk);
      chk("post_rst_chg_end", bus.changed, 0);

`ifdef SW_DEBOUNCE_EVT_EN
      bus.sw_in = 8'h01;
      repeat (10) @(negedge clk);
      bus.sw_in = 8'h03;
      repeat (6) @(negedge clk);
      chk("evt_x03", bus.x, 8'h03);
      @(negedge clk);
      chk("evt_rise02", bus.rise, 8'h02);
      chk("evt_chg_up", bus.changed, 1);
      @(negedge clk);
      chk("evt_rise_end", bus.rise, 0);
      bus.sw_in = 8'h01;
      repeat (6) @(negedge clk);
      chk("evt_x01", bus.x, 8'h01);
      @(negedge clk);
      chk("evt_fall_rise", bus.rise, 0);
      chk("evt_chg_down", bus.changed, 1);
`endif

      // Random bouncing in noisy/calm phases, with rare resets.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c % 40 == 0) noisy = ($urandom_range(0, 99) < 40) ? 1 : 0;
         r = int'($urandom_range(0, 999));
         rst_n = (r < 3) ? 1'b0 : 1'b1;
         if ((noisy != 0 && r < 450) || (noisy == 0 && r < 40)) begin
            idx = int'($urandom_range(0, NB - 1));
            if (idx == W) bus.en_in = ~bus.en_in;
            else bus.sw_in[idx] = ~bus.sw_in[idx];
         end
      end
      rst_n = 1'b1;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 20000, SHALL set the consecutive-cycle count a synchronized input must hold a new level before the output follows; legal range 1..65535.
- REQ-002: Parameter SW_W, default 8, SHALL set the switch vector width.
- REQ-003: clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
- REQ-004: rst_n  input  1  SHALL be the asynchronous, active-low reset.
- REQ-005: sw_in  input  SW_W  SHALL carry the raw, asynchronous, bouncing switch levels.
- REQ-006: en_in  input  1  SHALL carry the raw, asynchronous, bouncing enable switch.
- REQ-007: x  output  SW_W  SHALL carry the debounced switch levels, registered, for the downstream priority encoder.
- REQ-008: en  output  1  SHALL carry the debounced enable, registered.
- REQ-009: changed  output  1  SHALL pulse high for exactly one cycle in the cycle after any bit of {en, x} changes.

Function
- REQ-010: Each of the SW_W+1 inputs SHALL pass through a private two-flop synchronizer before any other logic.
- REQ-011: Each bit SHALL own a counter of width $clog2(DEBOUNCE_CYCLES+1).
- REQ-012: Synchronized level equal to stable level: the counter SHALL clear to 0.
- REQ-013: Synchronized level different from stable level: the counter SHALL increment by 1.
- REQ-014: The increment that would make the counter equal DEBOUNCE_CYCLES SHALL instead toggle the stable level and clear the counter in the same edge.
- REQ-015: Latency: a clean raw transition SHALL appear on the output exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw level.
- REQ-016: A raw pulse shorter than DEBOUNCE_CYCLES cycles at the synchronizer output SHALL leave the output unchanged; the counter SHALL restart from 0 on each bounce.
- REQ-017: Bits SHALL debounce independently; simultaneous changes on several bits SHALL each update on their own schedule.
- REQ-018: changed SHALL assert once when several bits change on the same edge.
- REQ-019: The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
- REQ-020: With DEBOUNCE_CYCLES=1, the output SHALL follow the synchronized input with one extra cycle of delay.

Reset
- REQ-021: While rst_n=0, all of the following SHALL be 0 immediately and asynchronously: synchronizer flops, counters, x, en, changed, and any event outputs.
- REQ-022: Reset asserted mid-count SHALL discard all partial counts.
- REQ-023: After rst_n deasserts, inputs already high SHALL reach the outputs after DEBOUNCE_CYCLES+2 edges, and changed SHALL pulse for that first change.

Configuration
- REQ-024: Macro SW_DEBOUNCE_EVT_EN defined: the block SHALL add output rise  SW_W, a one-cycle pulse per bit when that bit of x goes 0->1, aligned with changed.
- REQ-025: Macro SW_DEBOUNCE_EVT_EN undefined: port rise and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
- REQ-026: Package sw_debounce_pkg SHALL hold the constants SW_W_DEF=8 and DEBOUNCE_CYCLES_DEF=20000, plus the counter-width function.
- REQ-027: Sub-module deb_bit SHALL contain one synchronizer, one counter and one stable flop; sw_debounce SHALL instantiate it SW_W+1 times.
- REQ-028: Each deb_bit instance SHALL expose its stable level and a one-cycle toggle strobe.

Verification (DEBOUNCE_CYCLES=4)
- REQ-029: Reset, then sw_in=8'h00 held: x SHALL stay 8'h00 and changed SHALL stay 0 for 50 cycles.
- REQ-030: sw_in from 8'h00 to 8'h81 held clean: x SHALL become 8'h81 exactly 6 edges later, with a single changed pulse in the following cycle.
- REQ-031: sw_in[3] bounces high-low-high-low, 1 cycle each, then settles high: x[3] SHALL rise only once, 6 edges after the settle point.
- REQ-032: en_in pulse of 3 cycles: en SHALL remain 0 and changed SHALL remain 0.
- REQ-033: rst_n asserted after 3 of 4 counts: x SHALL be 0 at once; after release, the input SHALL need 6 full edges to appear.
- REQ-034: With SW_DEBOUNCE_EVT_EN, x from 8'h01 to 8'h03: rise SHALL equal 8'h02 for one cycle; x from 8'h03 to 8'h01: rise SHALL stay 0 and changed SHALL pulse.
